// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope sample capture path.
package scope_pkg;

    // One stored sample per display column.
    localparam int unsigned SamplesDefault = 640;
    // Accepted samples in WAIT_TRIG before a forced trigger (TRIG_TIMEOUT_EN builds only).
    localparam int unsigned TimeoutDefault = 1048576;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitTrig = 2'd1,
        StCapture  = 2'd2,
        StHold     = 2'd3
    } cap_state_e;

endpackage

// File: rtl/trigger_detect.sv
// Edge trigger for the capture FSM: tracks the previous valid sample and fires on the
// selected edge while armed. With TRIG_TIMEOUT_EN defined, a counter of accepted samples
// forces a trigger on the next valid sample once TIMEOUT samples passed without one.
module trigger_detect
    import scope_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_valid,
    input  logic sample_in,
    input  logic trig_pol,
    input  logic arm,
    output logic fire
);

    logic prev_sample_q;
    logic edge_hit;

    // Previous sample follows every valid strobe regardless of FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_sample_q <= 1'b0;
        end else if (sample_valid) begin
            prev_sample_q <= sample_in;
        end
    end

    assign edge_hit = sample_valid && (prev_sample_q != sample_in) && (sample_in == trig_pol);

`ifdef TRIG_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] timeout_cnt_q, timeout_cnt_d;
    logic            timed_out;

    assign timed_out = (timeout_cnt_q == CntW'(TIMEOUT));
    assign fire      = arm && sample_valid && (edge_hit || timed_out);

    // Count accepted samples while armed; saturate at TIMEOUT, clear when disarmed.
    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        if (!arm) begin
            timeout_cnt_d = '0;
        end else if (sample_valid && !fire && !timed_out) begin
            timeout_cnt_d = timeout_cnt_q + CntW'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    assign fire = arm && edge_hit;
`endif

endmodule

// File: rtl/sample_capture_ctrl.sv
// Sample capture controller: waits for an edge trigger, stores a decimated trace of SAMPLES
// one-bit samples into the write bank, then swaps display banks on the next vblank rise.
// Optional forced trigger after TIMEOUT idle samples is enabled by defining TRIG_TIMEOUT_EN.
// SAMPLES must be at least 2.
module sample_capture_ctrl
    import scope_pkg::*;
#(
    parameter int unsigned SAMPLES = SamplesDefault,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic                       sample_in,
    input  logic [7:0]                 graph_scale,
    input  logic                       trig_pol,
    input  logic                       run,
    input  logic                       vblank,
    output logic                       wr_en,
    output logic [$clog2(SAMPLES)-1:0] wr_addr,
    output logic                       wr_data,
    output logic                       wr_bank,
    output logic                       rd_bank,
    output logic                       busy,
    output logic                       frame_swap
);

    localparam int unsigned       AddrW    = $clog2(SAMPLES);
    localparam logic [AddrW-1:0] LastAddr = AddrW'(SAMPLES - 1);

    cap_state_e       state_q, state_d;
    logic [7:0]       scale_q, scale_d;
    logic [7:0]       dec_cnt_q, dec_cnt_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             wr_en_q, wr_en_d;
    logic [AddrW-1:0] wr_addr_q, wr_addr_d;
    logic             wr_data_q, wr_data_d;
    logic             wr_bank_q, wr_bank_d;
    logic             frame_swap_q, frame_swap_d;
    logic             vblank_q;
    logic             vblank_rise;
    logic             trig_fire;
    logic [AddrW-1:0] addr_next;

    trigger_detect #(
        .TIMEOUT (TIMEOUT)
    ) u_trigger_detect (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .trig_pol     (trig_pol),
        .arm          ((state_q == StWaitTrig) && run),
        .fire         (trig_fire)
    );

    assign vblank_rise = vblank && !vblank_q;
    assign addr_next   = addr_q + AddrW'(1);

    // Next-state, decimation and write-port logic.
    always_comb begin
        state_d      = state_q;
        scale_d      = scale_q;
        dec_cnt_d    = dec_cnt_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_bank_d    = wr_bank_q;
        frame_swap_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StWaitTrig;
                    scale_d = graph_scale;
                end
            end
            StWaitTrig: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (trig_fire) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = sample_in;
                    dec_cnt_d = '0;
                    addr_d    = '0;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (sample_valid) begin
                    if (dec_cnt_q == scale_q) begin
                        dec_cnt_d = '0;
                        addr_d    = addr_next;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_next;
                        wr_data_d = sample_in;
                        if (addr_next == LastAddr) begin
                            state_d = StHold;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q + 8'd1;
                    end
                end
            end
            StHold: begin
                // A rise coinciding with the final write is dropped; wait for the next one.
                if (vblank_rise && !wr_en_q) begin
                    wr_bank_d    = !wr_bank_q;
                    frame_swap_d = 1'b1;
                    state_d      = run ? StWaitTrig : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            scale_q      <= '0;
            dec_cnt_q    <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            wr_bank_q    <= 1'b0;
            frame_swap_q <= 1'b0;
            vblank_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            scale_q      <= scale_d;
            dec_cnt_q    <= dec_cnt_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_bank_q    <= wr_bank_d;
            frame_swap_q <= frame_swap_d;
            vblank_q     <= vblank;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = !wr_bank_q;
    assign frame_swap = frame_swap_q;
    assign busy       = (state_q == StWaitTrig) || (state_q == StCapture);

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Directed bench for sample_capture_ctrl (SAMPLES=640, TIMEOUT=16); the timeout scenario
// expects a forced trigger only when TRIG_TIMEOUT_EN is defined.
module tb_sample_capture_ctrl;

    localparam int unsigned Samples = 640;
    localparam int unsigned AddrW   = $clog2(Samples);

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_valid;
    logic             sample_in;
    logic [7:0]       graph_scale;
    logic             trig_pol;
    logic             run;
    logic             vblank;
    logic             wr_en;
    logic [AddrW-1:0] wr_addr;
    logic             wr_data;
    logic             wr_bank;
    logic             rd_bank;
    logic             busy;
    logic             frame_swap;

    int n_checks = 0;
    int n_fail   = 0;

    sample_capture_ctrl #(
        .SAMPLES (Samples),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .graph_scale  (graph_scale),
        .trig_pol     (trig_pol),
        .run          (run),
        .vblank       (vblank),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_bank      (wr_bank),
        .rd_bank      (rd_bank),
        .busy         (busy),
        .frame_swap   (frame_swap)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b0;
        run          = 1'b0;
        graph_scale  = 8'd0;
        trig_pol     = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 1'b0;
        vblank       = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Data pattern for post-trigger sample k.
    function automatic logic pat(input int k);
        int v;
        v = (k >> 1) ^ (k >> 4);
        return v[0];
    endfunction

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; sample_valid = 1'b1; sample_in = 1'b1; vblank = 1'b1;
        graph_scale = 8'h55; trig_pol = 1'b1;
        tick();
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        n_checks++; if (wr_data !== 1'b0) begin n_fail++; $display("FAIL reset_wr_data: got %b want 0", wr_data); end
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL reset_wr_bank: got %b want 0", wr_bank); end
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL reset_rd_bank: got %b want 1", rd_bank); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL reset_frame_swap: got %b want 0", frame_swap); end
    endtask

    // scale=0, rising trigger on stream 0,0,1: 640 consecutive writes, then HOLD.
    task automatic test_capture_scale0();
        int bad, writes, bad_k, bad_addr;
        logic bad_en, bad_data;
        apply_reset();
        run = 1'b1; graph_scale = 8'd0; trig_pol = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL s0_busy_wait: got %b want 1", busy); end
        sample_valid = 1'b1;
        sample_in = 1'b0; tick();
        sample_in = 1'b0; tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL s0_pretrig: wr_en got %b want 0", wr_en); end
        sample_in = 1'b1; tick();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 1'b1) begin
            n_fail++;
            $display("FAIL s0_trigger_write: en/addr/data got %b/%0d/%b want 1/0/1", wr_en, wr_addr, wr_data);
        end
        bad = 0; writes = 1; bad_k = 0; bad_en = 0; bad_addr = 0; bad_data = 0;
        for (int k = 1; k < 640; k++) begin
            sample_in = pat(k);
            tick();
            if (wr_en === 1'b1) writes++;
            if (wr_en !== 1'b1 || wr_addr !== AddrW'(k) || wr_data !== pat(k)) begin
                if (bad == 0) begin bad_k = k; bad_en = wr_en; bad_addr = int'(wr_addr); bad_data = wr_data; end
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL s0_stream: %0d bad writes, first k=%0d en/addr/data got %b/%0d/%b want 1/%0d/%b",
                     bad, bad_k, bad_en, bad_addr, bad_data, bad_k, pat(bad_k));
        end
        n_checks++; if (writes != 640) begin n_fail++; $display("FAIL s0_write_count: got %0d want 640", writes); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL s0_hold_busy: got %b want 0", busy); end
    endtask

    // Continues from the final write of test_capture_scale0: vblank rises in that cycle.
    task automatic test_swap_after_final_write();
        int pulses, extra_wr;
        pulses = 0; extra_wr = 0;
        vblank = 1'b1; sample_valid = 1'b1; sample_in = 1'b1;
        tick();
        if (frame_swap === 1'b1) pulses++;
        if (wr_en === 1'b1) extra_wr++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (frame_swap === 1'b1) pulses++;
            if (wr_en === 1'b1) extra_wr++;
        end
        vblank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (frame_swap === 1'b1) pulses++;
            if (wr_en === 1'b1) extra_wr++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL swap_ignored_rise: pulses got %0d want 0", pulses); end
        n_checks++; if (extra_wr != 0) begin n_fail++; $display("FAIL swap_no_wrap: writes got %0d want 0", extra_wr); end
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL swap_bank_before: got %b want 0", wr_bank); end
        sample_valid = 1'b0;
        vblank = 1'b1;
        tick();
        n_checks++; if (frame_swap !== 1'b1) begin n_fail++; $display("FAIL swap_pulse: got %b want 1", frame_swap); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL swap_wr_bank: got %b want 1", wr_bank); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL swap_rd_bank: got %b want 0", rd_bank); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL swap_rearm: busy got %b want 1", busy); end
        tick();
        n_checks++; if (frame_swap !== 1'b0) begin n_fail++; $display("FAIL swap_one_cycle: got %b want 0", frame_swap); end
        vblank = 1'b0;
    endtask

    // scale=3 (changed to 0 after latching), falling trigger, valid every other cycle.
    task automatic test_capture_scale3();
        int bad, writes, last_k, bad_k;
        logic exp_wr;
        apply_reset();
        run = 1'b1; graph_scale = 8'd3; trig_pol = 1'b0;
        tick();
        graph_scale = 8'd0;
        sample_valid = 1'b1;
        sample_in = 1'b1; tick();
        sample_in = 1'b1; tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL s3_pretrig: wr_en got %b want 0", wr_en); end
        sample_in = 1'b0; tick();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 1'b0) begin
            n_fail++;
            $display("FAIL s3_trigger_write: en/addr/data got %b/%0d/%b want 1/0/0", wr_en, wr_addr, wr_data);
        end
        bad = 0; writes = 1; last_k = 0; bad_k = -1;
        for (int k = 1; k <= 2556; k++) begin
            sample_valid = 1'b1; sample_in = pat(k);
            tick();
            exp_wr = ((k % 4) == 0);
            if (wr_en === 1'b1) begin writes++; last_k = k; end
            if (exp_wr) begin
                if (wr_en !== 1'b1 || wr_addr !== AddrW'(k / 4) || wr_data !== pat(k)) begin
                    if (bad == 0) bad_k = k;
                    bad++;
                end
            end else if (wr_en !== 1'b0) begin
                if (bad == 0) bad_k = k;
                bad++;
            end
            sample_valid = 1'b0; sample_in = !pat(k);
            tick();
            if (wr_en !== 1'b0) begin
                if (bad == 0) bad_k = k;
                bad++;
                writes++;
            end
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL s3_stream: %0d bad cycles, first at k=%0d, want 0", bad, bad_k); end
        n_checks++; if (writes != 640) begin n_fail++; $display("FAIL s3_write_count: got %0d want 640", writes); end
        n_checks++; if (last_k != 2556) begin n_fail++; $display("FAIL s3_last_write_k: got %0d want 2556", last_k); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL s3_hold_busy: got %b want 0", busy); end
        // run dropped while holding: swap still completes, then idle.
        run = 1'b0; vblank = 1'b1;
        tick();
        n_checks++; if (frame_swap !== 1'b1) begin n_fail++; $display("FAIL hold_stop_swap: got %b want 1", frame_swap); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL hold_stop_bank: got %b want 1", wr_bank); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_stop_idle: busy got %b want 0", busy); end
        vblank = 1'b0;
    endtask

    // run dropped right after the write at address 100.
    task automatic test_abort();
        int stray_wr, pulses;
        apply_reset();
        run = 1'b1; graph_scale = 8'd0; trig_pol = 1'b1;
        tick();
        sample_valid = 1'b1; sample_in = 1'b1;
        tick();
        for (int k = 1; k <= 100; k++) begin
            sample_in = pat(k);
            tick();
        end
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== AddrW'(100)) begin
            n_fail++;
            $display("FAIL abort_reach_100: en/addr got %b/%0d want 1/100", wr_en, wr_addr);
        end
        run = 1'b0; sample_in = 1'b1;
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_no_write: got %b want 0", wr_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy got %b want 0", busy); end
        stray_wr = 0; pulses = 0;
        for (int i = 0; i < 6; i++) begin
            sample_in = i[0];
            vblank = (i >= 3);
            tick();
            if (wr_en === 1'b1) stray_wr++;
            if (frame_swap === 1'b1) pulses++;
        end
        n_checks++; if (stray_wr != 0) begin n_fail++; $display("FAIL abort_stray_writes: got %0d want 0", stray_wr); end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_no_swap: pulses got %0d want 0", pulses); end
        n_checks++;
        if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_banks: wr/rd got %b/%b want 0/1", wr_bank, rd_bank);
        end
        sample_valid = 1'b0; vblank = 1'b0;
    endtask

    // Constant-0 input with TIMEOUT=16: forced trigger on valid sample 17 only when enabled.
    task automatic test_timeout();
        int early;
        apply_reset();
        run = 1'b1; graph_scale = 8'd0; trig_pol = 1'b1;
        tick();
        early = 0;
        sample_valid = 1'b1; sample_in = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (wr_en !== 1'b0) early++;
        end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL timeout_early: writes got %0d want 0", early); end
        tick();
`ifdef TRIG_TIMEOUT_EN
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_forced: en/addr/data got %b/%0d/%b want 1/0/0", wr_en, wr_addr, wr_data);
        end
        tick();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== AddrW'(1)) begin
            n_fail++;
            $display("FAIL timeout_capture: en/addr got %b/%0d want 1/1", wr_en, wr_addr);
        end
`else
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL timeout_none: wr_en got %b want 0", wr_en); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_waiting: busy got %b want 1", busy); end
`endif
        sample_valid = 1'b0;
    endtask

    // Reset asserted mid-capture: outputs return to reset values, no swap afterwards.
    task automatic test_reset_mid_capture();
        int pulses;
        apply_reset();
        run = 1'b1; graph_scale = 8'd0; trig_pol = 1'b1;
        tick();
        sample_valid = 1'b1; sample_in = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            sample_in = pat(k);
            tick();
        end
        reset = 1'b0; sample_in = 1'b1;
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_en: got %b want 0", wr_en); end
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL rmid_wr_addr: got %0d want 0", wr_addr); end
        n_checks++; if (wr_data !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_data: got %b want 0", wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++;
        if (wr_bank !== 1'b0 || rd_bank !== 1'b1 || frame_swap !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_banks: wr/rd/swap got %b/%b/%b want 0/1/0", wr_bank, rd_bank, frame_swap);
        end
        reset = 1'b1; run = 1'b0; sample_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            vblank = i[1];
            tick();
            if (frame_swap === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rmid_no_swap: pulses got %0d want 0", pulses); end
        vblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture_scale0();
        test_swap_after_final_write();
        test_capture_scale3();
        test_abort();
        test_timeout();
        test_reset_mid_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
